iob_cache_be_arbiter: RTL



---
 rtl/iob_cache_be_arbiter_pkg.sv | 14 +
 rtl/iob_rr_prio_enc.sv | 31 +++
 rtl/iob_cache_be_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared types for the cache back-end arbiter: FSM state encoding and beat-counter sizing.
package iob_cache_be_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Beat counter must hold 0..max_beats; keep at least one bit when the cap is disabled.
    function automatic int arb_beat_w(input int max_beats);
        return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Round-robin priority encoder: first set request strictly after ptr, wrapping around.
module iob_rr_prio_enc
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] sel,
    output logic             any_req
);

    logic [2*N-1:0] req_twice;
    logic [N-1:0]   req_rot;

    // Rotating the doubled vector puts requester ptr+1 at bit 0.
    assign req_twice = {req, req};
    assign req_rot   = N'(req_twice >> (int'(ptr) + 1));
    assign any_req   = |req;

    always_comb begin
        sel = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel = SEL_W'((int'(ptr) + 1 + k) % N);
            end
        end
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one native memory port among N cache back-ends.
// state    | meaning
// ARB_IDLE | no grant; mem_* driven to zero, arbitrating pending requests
// ARB_BUSY | grant_sel owns the memory port until it drops valid or hits the beat cap
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 0,
    parameter int SEL_W     = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          mem_valid,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ready,
    output logic                          busy,
    output logic [SEL_W-1:0]              grant_sel
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BEAT_W = arb_beat_w(MAX_BEATS);

    arb_state_t        state;
    logic [SEL_W-1:0]  prio_ptr;
    logic [SEL_W-1:0]  next_sel;
    logic [BEAT_W-1:0] beat_cnt;
    logic              any_req;
    logic              beat_done;
    logic              others_waiting;
    logic              cap_release;

    iob_rr_prio_enc #(
        .N     (N_MASTERS),
        .SEL_W (SEL_W)
    ) u_prio_enc (
        .req     (m_valid),
        .ptr     (prio_ptr),
        .sel     (next_sel),
        .any_req (any_req)
    );

    assign busy    = (state == ARB_BUSY);
    assign m_rdata = mem_rdata;

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        m_ready   = '0;
        if (busy) begin
            mem_valid          = m_valid[grant_sel];
            mem_addr           = m_addr[int'(grant_sel)*ADDR_W +: ADDR_W];
            mem_wdata          = m_wdata[int'(grant_sel)*DATA_W +: DATA_W];
            mem_wstrb          = m_wstrb[int'(grant_sel)*NBYTES +: NBYTES];
            m_ready[grant_sel] = mem_ready;
        end
    end

    assign beat_done      = mem_valid & mem_ready;
    assign others_waiting = |(m_valid & ~(N_MASTERS'(1) << grant_sel));
    // Forced release only on a completed beat, so a handshake is never split.
    assign cap_release    = (MAX_BEATS != 0) && beat_done && others_waiting &&
                            (int'(beat_cnt) + 1 >= MAX_BEATS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            grant_sel <= '0;
            prio_ptr  <= SEL_W'(N_MASTERS - 1);
            beat_cnt  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_sel <= next_sel;
                        beat_cnt  <= '0;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (beat_done && int'(beat_cnt) < MAX_BEATS) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                    if (!m_valid[grant_sel] || cap_release) begin
                        state    <= ARB_IDLE;
                        prio_ptr <= grant_sel;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
